// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE        = 2'b00,
    EXC_LD_MISALIGN = 2'b01,
    EXC_ST_MISALIGN = 2'b10,
    EXC_TIMEOUT     = 2'b11
  } exc_cause_e;

  // Size comes from funct3[1:0]; reserved size 2'b11 is checked like a word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] wd;
    case (funct3[1:0])
      SZ_BYTE: wd = {4{data[7:0]}};
      SZ_HALF: wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/half from a bus word and sign/zero-extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select by low address bits
  always_comb begin
    byte_s = 8'd0;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Sign or zero extension by access type
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  load_data = {24'd0, byte_s};
      F3_LH:   load_data = {{16{half_s[15]}}, half_s};
      F3_LHU:  load_data = {16'd0, half_s};
      F3_LW:   load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data bus FSM with timeout, store lane build,
// load alignment and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_W      = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        link_in,
  input  logic [2:0]  funct3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] fwd_mem_data,
  output logic        stall_out,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_cause
);

  state_e               state_r, state_s;
  logic [TIMEOUT_W-1:0] cnt_r;
  logic                 access_s, is_store_s, misaligned_s, cnt_last_s;
  logic                 issue_s, done_s, timeout_s, misal_s, pass_s;
  logic [31:0]          load_data_s, wb_data_s;
  logic                 wb_we_s;

  // A load wins when both read and write are asserted.
  assign access_s     = mem_read_in | mem_write_in;
  assign is_store_s   = mem_write_in & ~mem_read_in;
  assign misaligned_s = access_s & is_misaligned(funct3_in, alu_result_in[1:0]);
  assign cnt_last_s   = (cnt_r == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign fwd_mem_data = link_in ? pc_plus4_in : alu_result_in;
  assign wb_data_s    = link_in ? pc_plus4_in : (mem_to_reg_in ? load_data_s : alu_result_in);
  assign wb_we_s      = reg_write_in & (rd_addr_in != 5'd0);

  mem_stage_load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr_lo   (alu_result_in[1:0]),
    .funct3    (funct3_in),
    .load_data (load_data_s)
  );

  // Next-state, stall and MEM/WB load decisions
  always_comb begin
    state_s   = state_r;
    stall_out = 1'b0;
    issue_s   = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    misal_s   = 1'b0;
    pass_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (misaligned_s) begin
          misal_s = 1'b1;
        end else if (access_s) begin
          stall_out = 1'b1;
          issue_s   = 1'b1;
          state_s   = ST_BUSY;
        end else begin
          pass_s = 1'b1;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (cnt_last_s) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and BUSY cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {TIMEOUT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= (state_r == ST_BUSY) ? cnt_r + 1'b1 : {TIMEOUT_W{1'b0}};
    end
  end

  // Bus request registers, frozen for the whole transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
    end else if (issue_s) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store_s;
      dmem_addr  <= {alu_result_in[31:2], 2'b00};
      dmem_wdata <= is_store_s ? store_wdata(funct3_in, rs2_data_in) : 32'd0;
      dmem_be    <= is_store_s ? store_be(funct3_in, alu_result_in[1:0]) : 4'b1111;
    end else if (done_s || timeout_s) begin
      dmem_req <= 1'b0;
    end
  end

  // MEM/WB register; stalled, faulted and timed-out cycles become bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_result    <= 32'd0;
      wb_rd_addr   <= 5'd0;
      wb_reg_write <= 1'b0;
    end else if (pass_s || done_s) begin
      wb_result    <= wb_data_s;
      wb_rd_addr   <= rd_addr_in;
      wb_reg_write <= wb_we_s;
    end else begin
      wb_reg_write <= 1'b0;
    end
  end

  // Registered one-cycle fault pulse; cause persists until the next fault
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_exc       <= 1'b0;
      mem_exc_cause <= EXC_NONE;
    end else begin
      mem_exc <= misal_s | timeout_s;
      if (misal_s) begin
        mem_exc_cause <= mem_read_in ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
      end else if (timeout_s) begin
        mem_exc_cause <= EXC_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven, scoreboarded bench for mem_stage with a bus responder model.
module tb_mem_stage;

  logic        clk, rst;
  logic [31:0] pc_plus4_in, alu_result_in, rs2_data_in;
  logic [4:0]  rd_addr_in;
  logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, link_in;
  logic [2:0]  funct3_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] fwd_mem_data, wb_result;
  logic        stall_out, wb_reg_write, mem_exc;
  logic [4:0]  wb_rd_addr;
  logic [1:0]  mem_exc_cause;

  int checks = 0;
  int errors = 0;
  localparam int MAXC = 400;

  typedef struct {
    logic [31:0] alu, rs2, pc4, rdata;
    logic [4:0]  rd;
    logic        mr, mw, m2r, rw, link;
    logic [2:0]  f3;
    int          ack_dly;
    logic [31:0] e_res;
    logic        chk_res, e_rw, e_exc, e_req, e_we;
    logic [1:0]  e_cause;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_stalls;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  mem_stage dut (
    .clk(clk), .rst(rst),
    .pc_plus4_in(pc_plus4_in), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .rd_addr_in(rd_addr_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .link_in(link_in),
    .funct3_in(funct3_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .fwd_mem_data(fwd_mem_data), .stall_out(stall_out),
    .wb_result(wb_result), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.alu = 32'd0; v.rs2 = 32'd0; v.pc4 = 32'd0; v.rdata = 32'd0; v.rd = 5'd0;
    v.mr = 1'b0; v.mw = 1'b0; v.m2r = 1'b0; v.rw = 1'b0; v.link = 1'b0; v.f3 = 3'd0;
    v.ack_dly = 0; v.e_res = 32'd0; v.chk_res = 1'b0; v.e_rw = 1'b0; v.e_exc = 1'b0;
    v.e_req = 1'b0; v.e_we = 1'b0; v.e_cause = 2'd0; v.e_be = 4'd0; v.e_wdata = 32'd0;
    v.e_stalls = 0;
    return v;
  endfunction

  function automatic vec_t ld(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rdata, input int dly, input logic [31:0] res);
    vec_t v = blank();
    v.alu = addr; v.f3 = f3; v.mr = 1'b1; v.m2r = 1'b1; v.rw = 1'b1; v.rd = 5'd10;
    v.pc4 = 32'h0000_1004; v.ack_dly = dly; v.rdata = rdata;
    v.e_res = res; v.chk_res = 1'b1; v.e_rw = 1'b1; v.e_req = 1'b1; v.e_be = 4'hF;
    v.e_stalls = 1 + dly;
    return v;
  endfunction

  function automatic vec_t st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                              input int dly, input logic [3:0] be, input logic [31:0] wdata);
    vec_t v = blank();
    v.alu = addr; v.f3 = f3; v.mw = 1'b1; v.rs2 = data; v.ack_dly = dly;
    v.e_res = addr; v.chk_res = 1'b1; v.e_req = 1'b1; v.e_we = 1'b1; v.e_be = be;
    v.e_wdata = wdata; v.e_stalls = 1 + dly;
    return v;
  endfunction

  function automatic vec_t mis(input logic is_st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [1:0] cause);
    vec_t v = blank();
    v.alu = addr; v.f3 = f3; v.mr = ~is_st; v.mw = is_st; v.m2r = ~is_st; v.rw = ~is_st;
    v.rd = is_st ? 5'd0 : 5'd9; v.rs2 = 32'h5555_AAAA;
    v.e_exc = 1'b1; v.e_cause = cause;
    return v;
  endfunction

  function automatic vec_t alu(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] pc4,
                               input logic link, input logic [31:0] res, input logic erw);
    vec_t v = blank();
    v.rd = rd; v.alu = a; v.pc4 = pc4; v.link = link; v.rw = 1'b1;
    v.e_res = res; v.chk_res = 1'b1; v.e_rw = erw;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    alu_result_in = v.alu; rs2_data_in = v.rs2; pc_plus4_in = v.pc4; rd_addr_in = v.rd;
    mem_read_in = v.mr; mem_write_in = v.mw; mem_to_reg_in = v.m2r; reg_write_in = v.rw;
    link_in = v.link; funct3_in = v.f3;
  endtask

  task automatic run_op(input vec_t v);
    vec_t e;
    int busy, stalls;
    logic req_seen, done;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    busy = 0; stalls = 0; req_seen = 1'b0; done = 1'b0;
    for (int c = 0; c < MAXC && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (dmem_req) begin
        if (!req_seen) begin
          chk("dmem_addr", dmem_addr, v.alu & 32'hFFFF_FFFC);
          chk("dmem_be", {28'd0, dmem_be}, {28'd0, v.e_be});
          chk("dmem_we", {31'd0, dmem_we}, {31'd0, v.e_we});
          if (v.e_we) chk("dmem_wdata", dmem_wdata, v.e_wdata);
        end
        req_seen = 1'b1;
        dmem_ack = (v.ack_dly >= 0) && (busy == v.ack_dly);
        dmem_rdata = dmem_ack ? v.rdata : $urandom();
        busy++;
      end else begin
        dmem_ack = 1'b0;
        dmem_rdata = $urandom();
      end
      #1;
      if (stall_out) stalls++;
      else done = 1'b1;
    end
    if (!done) chk("op_completes", 32'd0, 32'd1);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    e = exp_q.pop_front();
    chk("stall_cycles", stalls, e.e_stalls);
    chk("bus_request_seen", {31'd0, req_seen}, {31'd0, e.e_req});
    chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.e_rw});
    chk("mem_exc", {31'd0, mem_exc}, {31'd0, e.e_exc});
    if (e.chk_res) chk("wb_result", wb_result, e.e_res);
    if (e.e_rw) chk("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, e.rd});
    if (e.e_exc) chk("mem_exc_cause", {30'd0, mem_exc_cause}, {30'd0, e.e_cause});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_dmem_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_dmem_be"}, {28'd0, dmem_be}, 32'd0);
    chk({tag, "_wb_result"}, wb_result, 32'd0);
    chk({tag, "_wb_rd_addr"}, {27'd0, wb_rd_addr}, 32'd0);
    chk({tag, "_wb_reg_write"}, {31'd0, wb_reg_write}, 32'd0);
    chk({tag, "_mem_exc"}, {31'd0, mem_exc}, 32'd0);
    chk({tag, "_mem_exc_cause"}, {30'd0, mem_exc_cause}, 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive(blank());
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    tbl.push_back(ld(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF));
    tbl.push_back(ld(3'b000, 32'h0000_0103, 32'h80FF_FFFF, 0, 32'hFFFF_FF80));
    tbl.push_back(ld(3'b100, 32'h0000_0103, 32'h80FF_FFFF, 1, 32'h0000_0080));
    tbl.push_back(ld(3'b001, 32'h0000_0102, 32'h8001_0000, 2, 32'hFFFF_8001));
    tbl.push_back(ld(3'b101, 32'h0000_0102, 32'h8001_0000, 0, 32'h0000_8001));
    tbl.push_back(ld(3'b000, 32'h0000_0101, 32'h0000_8000, 0, 32'hFFFF_FF80));
    tbl.push_back(ld(3'b001, 32'h0000_0100, 32'h1234_7FFF, 1, 32'h0000_7FFF));
    tbl.push_back(st(3'b000, 32'h0000_0101, 32'h0000_0012, 1, 4'b0010, 32'h1212_1212));
    tbl.push_back(st(3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5));
    tbl.push_back(st(3'b001, 32'h0000_0102, 32'hABCD_1234, 0, 4'b1100, 32'h1234_1234));
    tbl.push_back(st(3'b001, 32'h0000_0100, 32'hABCD_1234, 0, 4'b0011, 32'h1234_1234));
    tbl.push_back(st(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 2, 4'b1111, 32'hCAFE_F00D));
    tbl.push_back(mis(1'b0, 3'b010, 32'h0000_0102, 2'b01));
    tbl.push_back(alu(5'd7, 32'h0000_55AA, 32'h0, 1'b0, 32'h0000_55AA, 1'b1));
    tbl.push_back(mis(1'b1, 3'b001, 32'h0000_0101, 2'b10));
    tbl.push_back(alu(5'd1, 32'h0000_0999, 32'h0000_0208, 1'b1, 32'h0000_0208, 1'b1));
    tbl.push_back(alu(5'd0, 32'h0000_1234, 32'h0, 1'b0, 32'h0000_1234, 1'b0));
    tbl.push_back(mis(1'b0, 3'b001, 32'h0000_0103, 2'b01));
    v = ld(3'b010, 32'h0000_0108, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
    v.mw = 1'b1; v.rs2 = 32'hFFFF_FFFF;
    tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);

    // Timeout: 255 stalled BUSY cycles after the issue cycle, then release with cause 11
    v = ld(3'b010, 32'h0000_0200, 32'h0, -1, 32'h0);
    v.chk_res = 1'b0; v.e_rw = 1'b0; v.e_exc = 1'b1; v.e_cause = 2'b11; v.e_stalls = 256;
    run_op(v);

    // Late ack right after the timeout must be ignored
    @(negedge clk);
    drive(alu(5'd3, 32'h0000_0077, 32'h0, 1'b0, 32'h0, 1'b0));
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    chk("late_ack_stall", {31'd0, stall_out}, 32'd0);
    chk("late_ack_fwd", fwd_mem_data, 32'h0000_0077);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("late_ack_wb_result", wb_result, 32'h0000_0077);
    chk("late_ack_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("late_ack_mem_exc", {31'd0, mem_exc}, 32'd0);

    // Reset while a transfer is outstanding
    @(negedge clk);
    drive(ld(3'b010, 32'h0000_0300, 32'h0, 0, 32'h0));
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_reset_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    drive(blank());
    @(posedge clk); #1;
    chk_reset_state("mid_busy_reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(ld(3'b100, 32'h0000_0102, 32'h00AB_0000, 0, 32'h0000_00AB));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
